backend_flow_ctrl: RTL and testbench
====================================

// Module: backend_flow_ctrl
// PURPOSE
//  Central stall/clear sequencer for the two backend pipes (pipe0 = main/older, pipe1 = secondary/younger).
//  Collects per-stage stall and clear requests from both pipes.
//  Drives each pipe's 3-bit stall_vec/clr_vec (bit0 ex, bit1 m1, bit2 m2) and the frontend issue-hold and flush.
//  Holds clears that arrive while their stage is stalled; provides a stall watchdog and a stall-cycle counter.
// PARAMETERS
//  STALL_TIMEOUT  1024  consecutive any-stall cycles before deadlock_o sets
//  CNT_W          32    width of stall_cycles_o
// PORTS
//  clk                    in   1       clock
//  rst                    in   1       asynchronous, active-high reset
//  ex_stall_req_i         in   [1:0]   per-pipe ex stall request
//  m1_stall_req_i         in   [1:0]   per-pipe m1 stall request
//  m2_stall_req_i         in   [1:0]   per-pipe m2 stall request
//  ex_clr_req_i           in   [1:0]   per-pipe ex clear (branch redirect)
//  m1_clr_req_i           in   [1:0]   per-pipe m1 clear
//  m2_clr_req_i           in   [1:0]   per-pipe m2 clear (csr redirect/exception)
//  m2_clr_excl_self_i     in   [1:0]   m2 requester itself survives its clear
//  stall_vec_o            out  [1:0][2:0]  per-pipe stage stall
//  clr_vec_o              out  [1:0][2:0]  per-pipe kill of the instr leaving stage k
//  issue_stall_o          out  1       frontend must not issue
//  fe_flush_o             out  1       frontend flush, registered pulse
//  deadlock_o             out  1       sticky watchdog flag
//  stall_cycles_o         out  CNT_W   count of issue-stall cycles
// BEHAVIOUR
//  Reset: all registered outputs 0, FSM=RUN, pending clear empty, counters 0.
//   Reset mid-PEND drops the held clear.
//  Stall (combinational): s = highest stage with any stall_req in either pipe.
//   stall_vec_o[p][k]=1 for all k<=s, for both pipes. No request -> all 0.
//   issue_stall_o = stall_vec_o[0][0].
//  Clear winner: the oldest stage wins (m2>m1>ex). Within a stage, pipe0 beats pipe1.
//  Clear vector for winner (s,p):
//   - clr[q][k]=1 for all q and all k<s.
//   - At stage s: if p=0, clr[1][s]=1.
//   - The requester's own clr[p][s]=1 only when s=m2 and excl_self[p]=0.
//   - ex/m1 requesters always survive.
//  Clears act only when stall_vec_o[p][s]=0; in all other cases clr_vec_o=0.
//  FSM RUN:
//   - Winner, stage s not stalled -> drive its vector this cycle, stay RUN.
//   - Winner, stage s stalled -> latch {s,p,excl} into pend, go PEND, clr_vec_o=0.
//  FSM PEND:
//   - clr_vec_o=0 while stall_vec_o[pend.p][pend.s]=1.
//   - A new request from a strictly older stage, or same stage with p=0 over p=1, replaces pend.
//   - A younger request is ignored.
//   - On the first cycle pend's stage is unstalled: drive pend's vector for exactly 1 cycle, go RUN.
//   - If a live request is older than pend that cycle, drive the live request's vector instead.
//  fe_flush_o: registered; 1 in the cycle after any cycle with clr_vec_o!=0, otherwise 0.
//  Watchdog: run counter increments while any stall_vec bit=1, clears to 0 otherwise, saturates at STALL_TIMEOUT.
//   deadlock_o sets when the counter reaches STALL_TIMEOUT; only reset clears it.
//  stall_cycles_o increments each cycle issue_stall_o=1 and wraps mod 2^CNT_W.
//  Simultaneous stall and clear in the same stage/cycle -> PEND path; the clear is never lost.
// STRUCTURE
//  pipeline.svh: typedef enum {STG_EX, STG_M1, STG_M2} stage_e; struct clr_req_t{stage_e s; logic p; logic excl; logic vld}.
//  Sub-module clr_vec_gen: combinational clr_req_t -> [1:0][2:0] vector.
//   Instantiated twice: live winner and pend.
//  Top holds the 2-state FSM, pend register, watchdog, counter and fe_flush register.
// TESTING
//  1. m1_stall_req_i=2'b10 -> stall_vec_o=={3'b011,3'b011}, issue_stall_o=1; release -> all 0 next cycle.
//  2. m2_clr_req_i=2'b01, excl_self=0, no stall -> clr_vec_o[0]=3'b111, [1]=3'b111; fe_flush_o=1 the next cycle.
//  3. ex_clr_req_i=2'b01 -> clr_vec_o[0]=3'b000, [1]=3'b001; ex_clr from pipe1 only -> both 3'b000.
//  4. m1_clr_req pipe0 during m2_stall_req 3 cycles -> clr_vec_o=0 for 3 cycles.
//     Cycle of release: clr_vec_o[0]=3'b001, [1]=3'b011, exactly one cycle.
//  5. In PEND(m1), an m2 clr excl_self=1 on pipe0 arrives -> it replaces pend.
//     On release: [0]=3'b011, [1]=3'b111.
//  6. Hold ex_stall_req_i=1 for STALL_TIMEOUT cycles -> deadlock_o=1 and stays 1 after release.
//     stall_cycles_o==STALL_TIMEOUT; assert rst mid-PEND -> outputs 0 and no clear follows.

Source files
------------

// File: rtl/backend_flow_ctrl_pkg.sv
// Shared types for the backend stall/clear sequencer: stage and FSM
// encodings, the clear-request record and its priority ranking.
package backend_flow_ctrl_pkg;

  localparam int NUM_PIPES  = 2;
  localparam int NUM_STAGES = 3;

  // Backend stages, ordered young to old so a larger value is an older stage
  typedef enum logic [1:0] {
    STG_EX = 2'd0,
    STG_M1 = 2'd1,
    STG_M2 = 2'd2
  } stage_e;

  // One clear request: stage, requesting pipe, m2 self-exclusion and valid
  typedef struct packed {
    stage_e s;
    logic   p;
    logic   excl;
    logic   vld;
  } clr_req_t;

  typedef enum logic {
    FSM_RUN  = 1'b0,
    FSM_PEND = 1'b1
  } fsm_e;

  // Priority of a clear: older stage first, then pipe0 over pipe1.
  // A larger rank means a higher-priority clear.
  function automatic logic [2:0] clrRank(input clr_req_t req);
    return {req.s, ~req.p};
  endfunction

endpackage

// File: rtl/backend_flow_ctrl_clr_vec_gen.sv
// Expands a single clear request into the per-pipe, per-stage kill vector.
// Everything younger than the clearing stage dies in both pipes; at the
// clearing stage only the younger pipe dies, and the requester itself dies
// only for an m2 clear that does not exclude itself.
module backend_flow_ctrl_clr_vec_gen
  import backend_flow_ctrl_pkg::*;
(
  input  clr_req_t                                 i_req,
  output logic     [NUM_PIPES-1:0][NUM_STAGES-1:0] o_clrVec
);

  // Build the kill vector for the request from the stage/pipe ordering rules
  always_comb begin
    o_clrVec = '0;
    if (i_req.vld) begin
      case (i_req.s)
        STG_M1: begin
          o_clrVec[0][0] = 1'b1;
          o_clrVec[1][0] = 1'b1;
        end
        STG_M2: begin
          o_clrVec[0][1:0] = 2'b11;
          o_clrVec[1][1:0] = 2'b11;
        end
        default: ;
      endcase
      if (!i_req.p) begin
        o_clrVec[1][i_req.s] = 1'b1;
      end
      if ((i_req.s == STG_M2) && !i_req.excl) begin
        o_clrVec[i_req.p][2] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/backend_flow_ctrl.sv
// Central stall/clear sequencer for the two backend pipes. Stalls are a
// pure function of the current requests; clears that hit a stalled stage
// are parked in a pending slot until that stage moves, so none are lost.
// Also hosts the stall watchdog and the issue-stall cycle counter.
module backend_flow_ctrl
  import backend_flow_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic     [NUM_PIPES-1:0]                 ex_stall_req_i,
  input  logic     [NUM_PIPES-1:0]                 m1_stall_req_i,
  input  logic     [NUM_PIPES-1:0]                 m2_stall_req_i,
  input  logic     [NUM_PIPES-1:0]                 ex_clr_req_i,
  input  logic     [NUM_PIPES-1:0]                 m1_clr_req_i,
  input  logic     [NUM_PIPES-1:0]                 m2_clr_req_i,
  input  logic     [NUM_PIPES-1:0]                 m2_clr_excl_self_i,
  output logic     [NUM_PIPES-1:0][NUM_STAGES-1:0] stall_vec_o,
  output logic     [NUM_PIPES-1:0][NUM_STAGES-1:0] clr_vec_o,
  output logic                                     issue_stall_o,
  output logic                                     fe_flush_o,
  output logic                                     deadlock_o,
  output logic     [CNT_W-1:0]                     stall_cycles_o
);

  localparam int              WD_W   = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

  logic [NUM_STAGES-1:0]                 w_stallStages;
  logic                                  w_anyStall;
  clr_req_t                              w_liveReq;
  clr_req_t                              w_effReq;
  logic [NUM_PIPES-1:0][NUM_STAGES-1:0]  w_liveVec;
  logic [NUM_PIPES-1:0][NUM_STAGES-1:0]  w_pendVec;
  logic                                  w_liveBetter;
  logic                                  w_useLive;
  logic                                  w_effStalled;
  logic [WD_W-1:0]                       w_wdNext;

  fsm_e                                  r_state;
  clr_req_t                              r_pendReq;
  logic [WD_W-1:0]                       r_wdCount;
  logic                                  r_feFlush;
  logic                                  r_deadlock;
  logic [CNT_W-1:0]                      r_stallCycles;

  // A stall at any stage also holds every younger stage in both pipes
  always_comb begin
    w_stallStages[2] = |m2_stall_req_i;
    w_stallStages[1] = w_stallStages[2] | (|m1_stall_req_i);
    w_stallStages[0] = w_stallStages[1] | (|ex_stall_req_i);
    w_anyStall       = w_stallStages[0];
    stall_vec_o[0]   = w_stallStages;
    stall_vec_o[1]   = w_stallStages;
    issue_stall_o    = w_stallStages[0];
  end

  // Pick this cycle's winning clear: oldest stage first, pipe0 before pipe1
  always_comb begin
    w_liveReq = '0;
    if (m2_clr_req_i[0]) begin
      w_liveReq.vld = 1'b1; w_liveReq.s = STG_M2; w_liveReq.p = 1'b0;
    end else if (m2_clr_req_i[1]) begin
      w_liveReq.vld = 1'b1; w_liveReq.s = STG_M2; w_liveReq.p = 1'b1;
    end else if (m1_clr_req_i[0]) begin
      w_liveReq.vld = 1'b1; w_liveReq.s = STG_M1; w_liveReq.p = 1'b0;
    end else if (m1_clr_req_i[1]) begin
      w_liveReq.vld = 1'b1; w_liveReq.s = STG_M1; w_liveReq.p = 1'b1;
    end else if (ex_clr_req_i[0]) begin
      w_liveReq.vld = 1'b1; w_liveReq.s = STG_EX; w_liveReq.p = 1'b0;
    end else if (ex_clr_req_i[1]) begin
      w_liveReq.vld = 1'b1; w_liveReq.s = STG_EX; w_liveReq.p = 1'b1;
    end
    if (w_liveReq.vld) begin
      w_liveReq.excl = m2_clr_excl_self_i[w_liveReq.p];
    end
  end

  backend_flow_ctrl_clr_vec_gen u_liveGen (
    .i_req    (w_liveReq),
    .o_clrVec (w_liveVec)
  );

  backend_flow_ctrl_clr_vec_gen u_pendGen (
    .i_req    (r_pendReq),
    .o_clrVec (w_pendVec)
  );

  // Choose between the live winner and the held clear; a stalled target stage
  // suppresses the kill. Since stalls cover all younger stages, an older live
  // clear is never stalled while the held one is free.
  always_comb begin
    w_liveBetter = w_liveReq.vld &&
                   (!r_pendReq.vld || (clrRank(w_liveReq) > clrRank(r_pendReq)));
    w_useLive    = (r_state == FSM_RUN) || w_liveBetter;
    w_effReq     = w_useLive ? w_liveReq : r_pendReq;
    w_effStalled = w_stallStages[w_effReq.s];
    clr_vec_o    = '0;
    if (w_effReq.vld && !w_effStalled) begin
      clr_vec_o = w_useLive ? w_liveVec : w_pendVec;
    end
  end

  // Park stalled clears, let better ones replace them, release on unstall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FSM_RUN;
      r_pendReq <= '0;
    end else begin
      case (r_state)
        FSM_RUN: begin
          if (w_liveReq.vld && w_effStalled) begin
            r_pendReq <= w_liveReq;
            r_state   <= FSM_PEND;
          end
        end
        FSM_PEND: begin
          if (w_effStalled) begin
            r_pendReq <= w_effReq;
          end else begin
            r_pendReq <= '0;
            r_state   <= FSM_RUN;
          end
        end
        default: begin
          r_pendReq <= '0;
          r_state   <= FSM_RUN;
        end
      endcase
    end
  end

  // Consecutive-stall run length, saturating at the timeout
  always_comb begin
    w_wdNext = '0;
    if (w_anyStall) begin
      w_wdNext = (r_wdCount == WD_MAX) ? r_wdCount : r_wdCount + WD_W'(1);
    end
  end

  // Watchdog, sticky deadlock flag, issue-stall counter and frontend flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdCount     <= '0;
      r_deadlock    <= 1'b0;
      r_stallCycles <= '0;
      r_feFlush     <= 1'b0;
    end else begin
      r_wdCount <= w_wdNext;
      if (w_wdNext == WD_MAX) begin
        r_deadlock <= 1'b1;
      end
      if (issue_stall_o) begin
        r_stallCycles <= r_stallCycles + CNT_W'(1);
      end
      r_feFlush <= |clr_vec_o;
    end
  end

  assign fe_flush_o     = r_feFlush;
  assign deadlock_o     = r_deadlock;
  assign stall_cycles_o = r_stallCycles;

endmodule

// File: tb/tb_backend_flow_ctrl.sv
// Self-checking bench for backend_flow_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// stall/clear rules kept here.
module tb_backend_flow_ctrl;

  localparam int TO    = 64;
  localparam int CNT_W = 32;

  logic                   clk;
  logic                   rst;
  logic [1:0]             ex_stall_req_i;
  logic [1:0]             m1_stall_req_i;
  logic [1:0]             m2_stall_req_i;
  logic [1:0]             ex_clr_req_i;
  logic [1:0]             m1_clr_req_i;
  logic [1:0]             m2_clr_req_i;
  logic [1:0]             m2_clr_excl_self_i;
  logic [1:0][2:0]        stall_vec_o;
  logic [1:0][2:0]        clr_vec_o;
  logic                   issue_stall_o;
  logic                   fe_flush_o;
  logic                   deadlock_o;
  logic [CNT_W-1:0]       stall_cycles_o;

  int checkCount = 0;
  int passCount  = 0;

  // Model state
  int          mPendValid, mPendS, mPendP;
  logic        mPendX;
  int          mNextPendValid, mNextPendS, mNextPendP;
  logic        mNextPendX;
  int          mStallTop;
  logic [5:0]  mExpStall;
  logic [5:0]  mExpClr;
  logic        mFlush;
  logic        mDead;
  int          mRun;
  logic [31:0] mStallCnt;

  backend_flow_ctrl #(
    .STALL_TIMEOUT (TO),
    .CNT_W         (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_stall_req_i     (ex_stall_req_i),
    .m1_stall_req_i     (m1_stall_req_i),
    .m2_stall_req_i     (m2_stall_req_i),
    .ex_clr_req_i       (ex_clr_req_i),
    .m1_clr_req_i       (m1_clr_req_i),
    .m2_clr_req_i       (m2_clr_req_i),
    .m2_clr_excl_self_i (m2_clr_excl_self_i),
    .stall_vec_o        (stall_vec_o),
    .clr_vec_o          (clr_vec_o),
    .issue_stall_o      (issue_stall_o),
    .fe_flush_o         (fe_flush_o),
    .deadlock_o         (deadlock_o),
    .stall_cycles_o     (stall_cycles_o)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Kill vector from the rules: younger stages die in both pipes, the younger
  // pipe dies at the clearing stage when pipe0 clears, the requester dies only
  // for a non-excluding m2 clear. Bit index is pipe*3+stage.
  function automatic logic [5:0] clrVector(input int s, input int p, input logic x);
    logic [5:0] v;
    v = '0;
    for (int q = 0; q < 2; q++) begin
      for (int k = 0; k < s; k++) v[q*3+k] = 1'b1;
    end
    if (p == 0) v[3+s] = 1'b1;
    if ((s == 2) && !x) v[p*3+2] = 1'b1;
    return v;
  endfunction

  function automatic int rankOf(input int s, input int p);
    return s * 2 + ((p == 0) ? 1 : 0);
  endfunction

  task automatic resetModel();
    mPendValid = 0; mPendS = 0; mPendP = 0; mPendX = 1'b0;
    mFlush = 1'b0; mDead = 1'b0; mRun = 0; mStallCnt = '0;
  endtask

  // Drive one cycle of requests, predict the outputs and compare them
  task automatic applyStimulus(input logic [1:0] exS, input logic [1:0] m1S, input logic [1:0] m2S,
                               input logic [1:0] exC, input logic [1:0] m1C, input logic [1:0] m2C,
                               input logic [1:0] xs);
    logic [1:0] clrBy [3];
    int  liveValid, liveS, liveP;
    logic liveX;
    int  bestValid, bestS, bestP;
    logic bestX;
    ex_stall_req_i = exS; m1_stall_req_i = m1S; m2_stall_req_i = m2S;
    ex_clr_req_i = exC; m1_clr_req_i = m1C; m2_clr_req_i = m2C;
    m2_clr_excl_self_i = xs;

    mStallTop = -1;
    if (exS != 0) mStallTop = 0;
    if (m1S != 0) mStallTop = 1;
    if (m2S != 0) mStallTop = 2;
    mExpStall = '0;
    for (int k = 0; k < 3; k++) begin
      if (k <= mStallTop) begin
        mExpStall[k]   = 1'b1;
        mExpStall[3+k] = 1'b1;
      end
    end

    clrBy[0] = exC; clrBy[1] = m1C; clrBy[2] = m2C;
    liveValid = 0; liveS = 0; liveP = 0; liveX = 1'b0;
    for (int s = 2; s >= 0; s--) begin
      for (int p = 0; p < 2; p++) begin
        if ((liveValid == 0) && clrBy[s][p]) begin
          liveValid = 1; liveS = s; liveP = p; liveX = xs[p];
        end
      end
    end

    bestValid = 0; bestS = 0; bestP = 0; bestX = 1'b0;
    if (mPendValid != 0 && (liveValid == 0 || rankOf(mPendS, mPendP) >= rankOf(liveS, liveP))) begin
      bestValid = 1; bestS = mPendS; bestP = mPendP; bestX = mPendX;
    end else if (liveValid != 0) begin
      bestValid = 1; bestS = liveS; bestP = liveP; bestX = liveX;
    end

    mExpClr = '0;
    mNextPendValid = 0; mNextPendS = 0; mNextPendP = 0; mNextPendX = 1'b0;
    if (bestValid != 0) begin
      if (bestS <= mStallTop) begin
        mNextPendValid = 1; mNextPendS = bestS; mNextPendP = bestP; mNextPendX = bestX;
      end else begin
        mExpClr = clrVector(bestS, bestP, bestX);
      end
    end

    @(negedge clk);
    checkOutput("stall_vec", stall_vec_o, mExpStall);
    checkOutput("issue_stall", issue_stall_o, mExpStall[0]);
    checkOutput("clr_vec", clr_vec_o, mExpClr);
    checkOutput("fe_flush", fe_flush_o, mFlush);
    checkOutput("deadlock", deadlock_o, mDead);
    checkOutput("stall_cycles", stall_cycles_o, mStallCnt);
  endtask

  // Advance the model's registered state and move past the next clock edge
  task automatic endCycle();
    mFlush = (mExpClr != 0);
    mPendValid = mNextPendValid; mPendS = mNextPendS;
    mPendP = mNextPendP; mPendX = mNextPendX;
    if (mStallTop >= 0) begin
      if (mRun < TO) mRun++;
      mStallCnt = mStallCnt + 32'd1;
    end else begin
      mRun = 0;
    end
    if (mRun == TO) mDead = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    endCycle();
  endtask

  task automatic doReset();
    rst = 1'b1;
    ex_stall_req_i = '0; m1_stall_req_i = '0; m2_stall_req_i = '0;
    ex_clr_req_i = '0; m1_clr_req_i = '0; m2_clr_req_i = '0; m2_clr_excl_self_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_clr_vec", clr_vec_o, 6'b0);
    checkOutput("rst_fe_flush", fe_flush_o, 1'b0);
    checkOutput("rst_deadlock", deadlock_o, 1'b0);
    checkOutput("rst_stall_cycles", stall_cycles_o, '0);
    rst = 1'b0;
    resetModel();
  endtask

  function automatic logic [1:0] randBits(input int oneIn);
    logic [1:0] v;
    v[0] = ($urandom_range(0, oneIn - 1) == 0);
    v[1] = ($urandom_range(0, oneIn - 1) == 0);
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    resetModel();
    doReset();

    // m1 stall from pipe1 holds ex/m1 of both pipes, releases immediately
    applyStimulus(2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t1_stall", stall_vec_o, 6'b011011);
    checkOutput("t1_issue", issue_stall_o, 1'b1);
    endCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t1_release", stall_vec_o, 6'b0);
    endCycle();

    // m2 clear from pipe0 that kills itself, then the frontend flush pulse
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    checkOutput("t2_clr", clr_vec_o, 6'b111111);
    endCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t2_flush", fe_flush_o, 1'b1);
    endCycle();
    idle();

    // ex clears: pipe0 kills only pipe1 ex, pipe1 alone kills nothing
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    checkOutput("t3_ex_p0", clr_vec_o, 6'b001000);
    endCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    checkOutput("t3_ex_p1", clr_vec_o, 6'b000000);
    endCycle();
    idle();

    // m1 clear held across a 3-cycle m2 stall, released exactly once
    applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    checkOutput("t4_hold0", clr_vec_o, 6'b0);
    endCycle();
    for (int i = 1; i < 3; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      checkOutput("t4_hold", clr_vec_o, 6'b0);
      endCycle();
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t4_release", clr_vec_o, 6'b011001);
    endCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t4_once", clr_vec_o, 6'b0);
    endCycle();
    idle();

    // Older self-excluding m2 clear replaces a held m1 clear
    applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    endCycle();
    applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
    checkOutput("t5_hold", clr_vec_o, 6'b0);
    endCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t5_release", clr_vec_o, 6'b111011);
    endCycle();
    idle();

    // Watchdog: hold an ex stall for the full timeout
    doReset();
    for (int i = 0; i < TO; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      endCycle();
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t6_deadlock", deadlock_o, 1'b1);
    checkOutput("t6_cycles", stall_cycles_o, 32'(TO));
    endCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t6_sticky", deadlock_o, 1'b1);
    endCycle();

    // Reset while a clear is held must drop it
    doReset();
    applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    endCycle();
    applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    endCycle();
    doReset();
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t6_rst_noclr", clr_vec_o, 6'b0);
    endCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("t6_rst_noflush", fe_flush_o, 1'b0);
    endCycle();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(randBits(8), randBits(10), randBits(10),
                    randBits(5), randBits(6), randBits(7), randBits(2));
      endCycle();
    end

    $display("[TB] directed and random phases done");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
